// File: rtl/pp3_cfg_pkg.sv
// Shared constants, FSM state encoding and helpers for the PP3 logic-cell config loader.
// PP3_CFG_CHECKSUM_EN adds the trailing-checksum states.
package pp3_cfg_pkg;

  localparam logic [7:0] CMD_WRITE  = 8'hA5;
  localparam logic [7:0] CMD_READ   = 8'h5A;
  localparam logic [7:0] CMD_CLRERR = 8'hC3;

  // Bit positions of the inverter selects inside one cell's config byte.
  typedef enum int {
    TAS1 = 0,
    TAS2 = 1,
    TBS1 = 2,
    TBS2 = 3,
    BAS1 = 4,
    BAS2 = 5,
    BBS1 = 6,
    BBS2 = 7
  } cfg_bit_e;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    HADDR  = 4'd1,
    HCNT   = 4'd2,
    WDATA  = 4'd3,
    COMMIT = 4'd4,
    RDATA  = 4'd5,
    DRAIN  = 4'd6
`ifdef PP3_CFG_CHECKSUM_EN
    ,
    WCHK   = 4'd7,
    RCHK   = 4'd8
`endif
  } state_e;

  function automatic logic accepts_bytes(input state_e s);
    logic a;
    a = (s == IDLE) || (s == HADDR) || (s == HCNT) || (s == WDATA) || (s == DRAIN);
`ifdef PP3_CFG_CHECKSUM_EN
    a = a || (s == WCHK);
`endif
    return a;
  endfunction

endpackage

// File: rtl/pp3_cfg_frame_ctr.sv
// Frame cell pointer, remaining-count down-counter and range check for the config loader.
module pp3_cfg_frame_ctr
  import pp3_cfg_pkg::*;
#(
  parameter int NUM_CELLS = 16,
  parameter int ADDR_W    = 4
) (
  input  logic              QCK,
  input  logic              QRN,
  input  logic              ld_addr,
  input  logic              ld_cnt,
  input  logic              step,
  input  logic [7:0]        in_byte,
  output logic [ADDR_W-1:0] ptr,
  output logic              last,
  output logic              range_err
);

  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [7:0]        rem_q, rem_d;
  logic [9:0]        span;

  always_comb begin
    ptr_d = ptr_q;
    rem_d = rem_q;
    if (ld_addr) ptr_d = in_byte[ADDR_W-1:0];
    if (ld_cnt)  rem_d = in_byte;
    if (step) begin
      ptr_d = ptr_q + ADDR_W'(1);
      rem_d = rem_q - 8'd1;
    end
  end

  always_ff @(posedge QCK or negedge QRN) begin
    if (!QRN) begin
      ptr_q <= '0;
      rem_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      rem_q <= rem_d;
    end
  end

  // Evaluated while the CNT byte is on in_byte and ptr still holds the start address.
  assign span      = 10'(ptr_q) + 10'(in_byte) + 10'd1;
  assign range_err = (span > 10'(NUM_CELLS));
  assign last      = (rem_q == 8'd0);
  assign ptr       = ptr_q;

endmodule

// File: rtl/pp3_lcell_cfg_loader.sv
// Byte-stream config writer/readback for a column of PP3 logic cells (shadow + atomic commit).
// Optional trailing XOR checksum in both directions when PP3_CFG_CHECKSUM_EN is defined.
//   state  | meaning
//   IDLE   | waiting for a command byte
//   HADDR  | waiting for the start cell address
//   HCNT   | waiting for the cell count, range check
//   WDATA  | payload bytes written into the shadow
//   WCHK   | trailing checksum byte (checksum builds only)
//   COMMIT | shadow copied to the live config
//   RDATA  | live config streamed out on rb_*
//   RCHK   | readback checksum byte (checksum builds only)
//   DRAIN  | payload of a rejected write discarded
module pp3_lcell_cfg_loader
  import pp3_cfg_pkg::*;
#(
  parameter int NUM_CELLS = 16,
  parameter int CFG_BITS  = 8,
  parameter int ADDR_W    = 4
) (
  input  logic                          QCK,
  input  logic                          QRN,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [7:0]                    in_data,
  output logic                          rb_valid,
  input  logic                          rb_ready,
  output logic [7:0]                    rb_data,
  output logic [NUM_CELLS*CFG_BITS-1:0] cfg_active,
  output logic                          cfg_commit,
  output logic                          busy,
  output logic                          err
);

  localparam int CFG_W = NUM_CELLS * CFG_BITS;

  state_e             state_q, state_d;
  logic [CFG_W-1:0]   shadow_q, shadow_d;
  logic [CFG_W-1:0]   active_q, active_d;
  logic               is_write_q, is_write_d;
  logic               err_q, err_d;
  logic               commit_q, commit_d;
  logic               in_ready_q, in_ready_d;
  logic               in_fire;
  logic               ld_addr, ld_cnt, step;
  logic [ADDR_W-1:0]  ptr;
  logic               last, range_err;
  logic [CFG_BITS-1:0] rd_cell;
  logic [7:0]         rb_data_c;
`ifdef PP3_CFG_CHECKSUM_EN
  logic [7:0]         chk_q, chk_d;
`endif

  pp3_cfg_frame_ctr #(
    .NUM_CELLS(NUM_CELLS),
    .ADDR_W   (ADDR_W)
  ) u_frame_ctr (
    .QCK      (QCK),
    .QRN      (QRN),
    .ld_addr  (ld_addr),
    .ld_cnt   (ld_cnt),
    .step     (step),
    .in_byte  (in_data),
    .ptr      (ptr),
    .last     (last),
    .range_err(range_err)
  );

  assign in_fire = in_valid && in_ready_q;
  assign rd_cell = active_q[int'(ptr)*CFG_BITS +: CFG_BITS];

  always_comb begin
    state_d    = state_q;
    err_d      = err_q;
    is_write_d = is_write_q;
    shadow_d   = shadow_q;
    active_d   = active_q;
    commit_d   = 1'b0;
    ld_addr    = 1'b0;
    ld_cnt     = 1'b0;
    step       = 1'b0;
    case (state_q)
      IDLE: if (in_fire) begin
        case (in_data)
          CMD_WRITE: begin
            is_write_d = 1'b1;
            state_d    = HADDR;
          end
          CMD_READ: begin
            is_write_d = 1'b0;
            state_d    = HADDR;
          end
          CMD_CLRERR: err_d = 1'b0;
          default:    err_d = 1'b1;
        endcase
      end
      HADDR: if (in_fire) begin
        ld_addr = 1'b1;
        state_d = HCNT;
      end
      HCNT: if (in_fire) begin
        ld_cnt = 1'b1;
        if (range_err) begin
          err_d   = 1'b1;
          state_d = is_write_q ? DRAIN : IDLE;
        end else if (is_write_q) begin
          // Reload so cells outside the frame keep their live values at commit.
          shadow_d = active_q;
          state_d  = WDATA;
        end else begin
          state_d = RDATA;
        end
      end
      WDATA: if (in_fire) begin
        shadow_d[int'(ptr)*CFG_BITS +: CFG_BITS] = in_data[CFG_BITS-1:0];
        step = 1'b1;
`ifdef PP3_CFG_CHECKSUM_EN
        if (last) state_d = WCHK;
`else
        if (last) state_d = COMMIT;
`endif
      end
`ifdef PP3_CFG_CHECKSUM_EN
      WCHK: if (in_fire) begin
        if (in_data == chk_q) begin
          state_d = COMMIT;
        end else begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
`endif
      COMMIT: begin
        active_d = shadow_q;
        commit_d = 1'b1;
        state_d  = IDLE;
      end
      RDATA: if (rb_ready) begin
        step = 1'b1;
`ifdef PP3_CFG_CHECKSUM_EN
        if (last) state_d = RCHK;
`else
        if (last) state_d = IDLE;
`endif
      end
`ifdef PP3_CFG_CHECKSUM_EN
      RCHK: if (rb_ready) state_d = IDLE;
`endif
      DRAIN: if (in_fire) begin
        step = 1'b1;
        if (last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = accepts_bytes(state_d);
  end

`ifdef PP3_CFG_CHECKSUM_EN
  // Write: running XOR of CMD, ADDR, CNT and payload. Read: XOR of returned cells.
  always_comb begin
    chk_d = chk_q;
    if (in_fire && state_q == IDLE) begin
      chk_d = in_data;
    end else if (in_fire && (state_q == HADDR || state_q == HCNT || state_q == WDATA)) begin
      chk_d = chk_q ^ in_data;
      if (state_q == HCNT && !is_write_q) chk_d = 8'h00;
    end else if (state_q == RDATA && rb_ready) begin
      chk_d = chk_q ^ 8'(rd_cell);
    end
  end

  always_ff @(posedge QCK or negedge QRN) begin
    if (!QRN) chk_q <= 8'h00;
    else      chk_q <= chk_d;
  end
`endif

  always_comb begin
    rb_data_c = 8'h00;
    if (state_q == RDATA) rb_data_c = 8'(rd_cell);
`ifdef PP3_CFG_CHECKSUM_EN
    if (state_q == RCHK) rb_data_c = chk_q;
`endif
  end

  always_ff @(posedge QCK or negedge QRN) begin
    if (!QRN) begin
      state_q    <= IDLE;
      shadow_q   <= '0;
      active_q   <= '0;
      is_write_q <= 1'b0;
      err_q      <= 1'b0;
      commit_q   <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      active_q   <= active_d;
      is_write_q <= is_write_d;
      err_q      <= err_d;
      commit_q   <= commit_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign cfg_active = active_q;
  assign cfg_commit = commit_q;
  assign err        = err_q;
  assign busy       = (state_q != IDLE);
`ifdef PP3_CFG_CHECKSUM_EN
  assign rb_valid   = (state_q == RDATA) || (state_q == RCHK);
`else
  assign rb_valid   = (state_q == RDATA);
`endif
  assign rb_data    = rb_data_c;

endmodule
